inst_fetch_queue: RTL and testbench

- Instruction buffer between the fetch stage and the dual-issue decode stage.
- Accepts up to two fetched instruction words plus their PCs per cycle, stores them in a circular queue, and presents the two oldest entries to decode every cycle.
- Decode consumes 0, 1 or 2 entries per cycle.
- Flush (branch redirect or exception/eret) empties the queue in one cycle.

---
 rtl/inst_fetch_queue.sv | 94 +++++++++
 tb/tb_inst_fetch_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Circular instruction buffer between fetch and dual-issue decode.
// Accepts up to two {pc, inst} pairs per cycle and presents the two oldest entries.
module inst_fetch_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic [1:0]       in_valid,
  input  logic [31:0]      in_pc0,
  input  logic [31:0]      in_inst0,
  input  logic [31:0]      in_pc1,
  input  logic [31:0]      in_inst1,
  output logic             in_ready,
  output logic             out_valid0,
  output logic [31:0]      out_pc0,
  output logic [31:0]      out_inst0,
  output logic             out_valid1,
  output logic [31:0]      out_pc1,
  output logic [31:0]      out_inst1,
  input  logic [1:0]       pop_num,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] ReadyMax = (PTR_W+1)'(DEPTH - 2);

  logic [63:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic             accept;
  logic             we0, we1;
  logic [1:0]       push_num;

  assign head_p1 = head_q + PTR_W'(1);
  assign tail_p1 = tail_q + PTR_W'(1);

  // Two free slots are required so a full dual push can never collide with the head.
  assign in_ready = (count_q <= ReadyMax);
  assign accept   = in_ready & ~flush;
  assign we0      = accept & in_valid[0];
  assign we1      = accept & in_valid[1];

  always_comb begin
    push_num = {1'b0, we0} + {1'b0, we1};
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_num);
      tail_d  = tail_q + PTR_W'(push_num);
      count_d = count_q + (PTR_W+1)'(push_num) - (PTR_W+1)'(pop_num);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; validity comes solely from count.
  always_ff @(posedge clk) begin
    if (we0) mem_q[tail_q]  <= {in_pc0, in_inst0};
    if (we1) mem_q[tail_p1] <= {in_pc1, in_inst1};
  end

  always_comb begin
    out_valid0 = (count_q != '0);
    out_valid1 = (count_q >= (PTR_W+1)'(2));
    out_pc0    = '0;
    out_inst0  = '0;
    out_pc1    = '0;
    out_inst1  = '0;
    if (out_valid0) {out_pc0, out_inst0} = mem_q[head_q];
    if (out_valid1) {out_pc1, out_inst1} = mem_q[head_p1];
  end

  assign count = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed vector table plus reset, wrap and
// dual-push sequences.
module tb_inst_fetch_queue;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic [1:0]  in_valid;
  logic [31:0] in_pc0, in_inst0, in_pc1, in_inst1;
  logic        in_ready;
  logic        out_valid0, out_valid1;
  logic [31:0] out_pc0, out_inst0, out_pc1, out_inst1;
  logic [1:0]  pop_num;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  inst_fetch_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_pc0     (in_pc0),
    .in_inst0   (in_inst0),
    .in_pc1     (in_pc1),
    .in_inst1   (in_inst1),
    .in_ready   (in_ready),
    .out_valid0 (out_valid0),
    .out_pc0    (out_pc0),
    .out_inst0  (out_inst0),
    .out_valid1 (out_valid1),
    .out_pc1    (out_pc1),
    .out_inst1  (out_inst1),
    .pop_num    (pop_num),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic [1:0]  in_valid;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [1:0]  pop;
    logic [3:0]  exp_cnt;
    logic        exp_v0;
    logic        exp_v1;
    logic [31:0] exp_pc0;
    logic [31:0] exp_pc1;
    logic        exp_rdy;
  } vec_t;

  localparam int NumVec = 17;
  vec_t vecs [NumVec];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    flush    = 1'b0;
    in_valid = 2'b00;
    in_pc0   = '0;
    in_inst0 = '0;
    in_pc1   = '0;
    in_inst1 = '0;
    pop_num  = 2'd0;
  endtask

  // Drive one cycle of stimulus; outputs are sampled 1ns after the edge by the caller.
  task automatic step(input logic fl, input logic [1:0] iv, input logic [31:0] p0,
                      input logic [31:0] i0, input logic [31:0] p1, input logic [31:0] i1,
                      input logic [1:0] pn);
    flush    = fl;
    in_valid = iv;
    in_pc0   = p0;
    in_inst0 = i0;
    in_pc1   = p1;
    in_inst1 = i1;
    pop_num  = pn;
    @(posedge clk);
    #1;
    idle();
  endtask

  // Illegal stimulus would make results undefined, so flag it as a failure.
  always @(negedge clk) begin
    if (resetn && (in_valid == 2'b10 || pop_num == 2'd3 ||
                   pop_num > ({1'b0, out_valid0} + {1'b0, out_valid1}))) begin
      errors++;
      $display("FAIL illegal_stim: in_valid=%b pop_num=%0d count=%0d", in_valid, pop_num, count);
    end
  end

  initial begin
    int npush, npop, cyc;
    logic [1:0] pn;
    logic [1:0] iv;
    logic tog;

    //          fl iv    pc0       pc1       pop cnt v0 v1 epc0      epc1      rdy
    vecs[0]  = '{0, 2'b11, 32'h100, 32'h104, 0, 2, 1, 1, 32'h100, 32'h104, 1};
    vecs[1]  = '{0, 2'b01, 32'h108, 32'h0,   1, 2, 1, 1, 32'h104, 32'h108, 1};
    vecs[2]  = '{0, 2'b00, 32'h0,   32'h0,   2, 0, 0, 0, 32'h0,   32'h0,   1};
    vecs[3]  = '{0, 2'b11, 32'h200, 32'h204, 0, 2, 1, 1, 32'h200, 32'h204, 1};
    vecs[4]  = '{0, 2'b11, 32'h208, 32'h20C, 0, 4, 1, 1, 32'h200, 32'h204, 1};
    vecs[5]  = '{0, 2'b11, 32'h210, 32'h214, 0, 6, 1, 1, 32'h200, 32'h204, 1};
    vecs[6]  = '{0, 2'b11, 32'h218, 32'h21C, 0, 8, 1, 1, 32'h200, 32'h204, 0};
    vecs[7]  = '{0, 2'b11, 32'h300, 32'h304, 1, 7, 1, 1, 32'h204, 32'h208, 0};
    vecs[8]  = '{0, 2'b11, 32'h310, 32'h314, 0, 7, 1, 1, 32'h204, 32'h208, 0};
    vecs[9]  = '{0, 2'b00, 32'h0,   32'h0,   1, 6, 1, 1, 32'h208, 32'h20C, 1};
    vecs[10] = '{0, 2'b11, 32'h220, 32'h224, 2, 6, 1, 1, 32'h210, 32'h214, 1};
    vecs[11] = '{0, 2'b00, 32'h0,   32'h0,   2, 4, 1, 1, 32'h218, 32'h21C, 1};
    vecs[12] = '{0, 2'b00, 32'h0,   32'h0,   2, 2, 1, 1, 32'h220, 32'h224, 1};
    vecs[13] = '{0, 2'b00, 32'h0,   32'h0,   1, 1, 1, 0, 32'h224, 32'h0,   1};
    vecs[14] = '{1, 2'b11, 32'h400, 32'h404, 1, 0, 0, 0, 32'h0,   32'h0,   1};
    vecs[15] = '{0, 2'b00, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0,   32'h0,   1};
    vecs[16] = '{0, 2'b01, 32'h500, 32'h0,   0, 1, 1, 0, 32'h500, 32'h0,   1};

    idle();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count",  32'(count),      32'd0);
    chk("rst_valid0", 32'(out_valid0), 32'd0);
    chk("rst_valid1", 32'(out_valid1), 32'd0);
    chk("rst_ready",  32'(in_ready),   32'd1);
    chk("rst_pc0",    out_pc0,         32'h0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NumVec; i++) begin
      step(vecs[i].flush, vecs[i].in_valid, vecs[i].pc0, ~vecs[i].pc0,
           vecs[i].pc1, ~vecs[i].pc1, vecs[i].pop);
      chk($sformatf("v%0d_count", i),  32'(count),      32'(vecs[i].exp_cnt));
      chk($sformatf("v%0d_valid0", i), 32'(out_valid0), 32'(vecs[i].exp_v0));
      chk($sformatf("v%0d_valid1", i), 32'(out_valid1), 32'(vecs[i].exp_v1));
      chk($sformatf("v%0d_ready", i),  32'(in_ready),   32'(vecs[i].exp_rdy));
      chk($sformatf("v%0d_pc0", i),    out_pc0,         vecs[i].exp_pc0);
      chk($sformatf("v%0d_pc1", i),    out_pc1,         vecs[i].exp_pc1);
      chk($sformatf("v%0d_inst0", i),  out_inst0,
          vecs[i].exp_v0 ? ~vecs[i].exp_pc0 : 32'h0);
      chk($sformatf("v%0d_inst1", i),  out_inst1,
          vecs[i].exp_v1 ? ~vecs[i].exp_pc1 : 32'h0);
    end

    // Asynchronous reset mid-operation with count=5.
    step(0, 2'b11, 32'h600, 32'h0, 32'h604, 32'h0, 0);
    step(0, 2'b11, 32'h608, 32'h0, 32'h60C, 32'h0, 0);
    chk("pre_rst_count", 32'(count), 32'd5);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_count",  32'(count),      32'd0);
    chk("async_rst_valid0", 32'(out_valid0), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_count", 32'(count),    32'd0);

    // Dual push then dual pop with real boot-code words.
    step(0, 2'b11, 32'hBFC00000, 32'h24080001, 32'hBFC00004, 32'h24090002, 0);
    chk("dp_count", 32'(count), 32'd2);
    chk("dp_pc0",   out_pc0,    32'hBFC00000);
    chk("dp_inst0", out_inst0,  32'h24080001);
    chk("dp_pc1",   out_pc1,    32'hBFC00004);
    chk("dp_inst1", out_inst1,  32'h24090002);
    step(0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2);
    chk("dpop_count",  32'(count),      32'd0);
    chk("dpop_valid0", 32'(out_valid0), 32'd0);
    chk("dpop_valid1", 32'(out_valid1), 32'd0);

    // Wrap-around ordering: head/tail start at 2, ten entries cross index 7->0.
    npush = 0;
    npop  = 0;
    tog   = 1'b0;
    cyc   = 0;
    while (npop < 10 && cyc < 60) begin
      pn = tog ? 2'd2 : 2'd1;
      if (32'(pn) > 32'(count)) pn = 2'(count);
      if (pn >= 2'd1) begin
        chk($sformatf("wrap_pc0_%0d", npop),   out_pc0,   32'h1000 + 32'(4 * npop));
        chk($sformatf("wrap_inst0_%0d", npop), out_inst0, ~(32'h1000 + 32'(4 * npop)));
      end
      if (pn == 2'd2)
        chk($sformatf("wrap_pc1_%0d", npop + 1), out_pc1, 32'h1000 + 32'(4 * (npop + 1)));
      iv = (npush < 10 && in_ready) ? 2'b11 : 2'b00;
      step(0, iv, 32'h1000 + 32'(4 * npush), ~(32'h1000 + 32'(4 * npush)),
           32'h1000 + 32'(4 * (npush + 1)), ~(32'h1000 + 32'(4 * (npush + 1))), pn);
      if (iv == 2'b11) npush += 2;
      npop += int'(pn);
      if (pn != 2'd0) tog = ~tog;
      cyc++;
    end
    chk("wrap_popped", 32'(npop),  32'd10);
    chk("wrap_count",  32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
